dxi_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the DXI filter input of dxi_top. It accepts a raster-order 8-bit pixel stream on a DXI slave port and buffers two image lines internally. For every fully interior window position it emits one 72-bit 3x3 window on a DXI master port. Output uses "valid" convolution: no border padding, so a frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

---
 rtl/dxi_window_gen.sv | 59 +++++
 tb/tb_dxi_window_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dxi_window_gen.sv
// dxi_window_gen: streaming 3x3 valid-convolution window generator with two line buffers
module dxi_window_gen #(
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_dxi_valid,
   input  logic [7:0]  i_dxi_data,
   output logic        o_dxi_ready,
   output logic        o_dxi_out_valid,
   output logic [71:0] o_dxi_out_data,
   input  logic        i_dxi_out_ready,
   output logic        o_dxi_out_last
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    lb0 [IMG_WIDTH];
   logic [7:0]    lb1 [IMG_WIDTH];
   logic [71:0]   win;
   logic [71:0]   win_nxt;
   logic          acc;
   logic          col_end;
   logic          row_end;
   logic          emit;
   assign o_dxi_ready = !o_dxi_out_valid || i_dxi_out_ready;
   assign acc         = i_dxi_valid && o_dxi_ready;
   assign col_end     = col == CW'(IMG_WIDTH - 1);
   assign row_end     = row == RW'(IMG_HEIGHT - 1);
   assign emit        = row >= RW'(2) && col >= CW'(2);
   // shift the window one column left; new right column is {lb1, lb0, pixel} from the old buffers
   assign win_nxt = {i_dxi_data, win[71:56], lb0[col], win[47:32], lb1[col], win[23:8]};
   // raster counters and the one-deep output register
   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
         col             <= '0;
         row             <= '0;
         o_dxi_out_valid <= 1'b0;
         o_dxi_out_last  <= 1'b0;
         o_dxi_out_data  <= '0;
      end else if (acc) begin
         col             <= col_end ? '0 : col + CW'(1);
         row             <= col_end ? (row_end ? '0 : row + RW'(1)) : row;
         o_dxi_out_valid <= emit;
         o_dxi_out_last  <= emit && col_end && row_end;
         if (emit) o_dxi_out_data <= win_nxt;
      end else if (i_dxi_out_ready) begin
         o_dxi_out_valid <= 1'b0;
      end
   // line buffers and window register hold pixel data only, so they carry no reset
   always_ff @(posedge i_clk)
      if (acc) begin
         lb1[col] <= lb0[col];
         lb0[col] <= i_dxi_data;
         win      <= win_nxt;
      end
endmodule

// File: tb/tb_dxi_window_gen.sv
// tb_dxi_window_gen: randomized self-checking bench for dxi_window_gen against a frame-level window model
module tb_dxi_window_gen;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        v [3];
   logic [7:0]  d [3];
   logic        rdy [3];
   logic        ov [3];
   logic [71:0] od [3];
   logic        ordy [3];
   logic        ol [3];
   int          W [3] = '{4, 8, 5};
   int          H [3] = '{4, 8, 4};
   int          rr [3];
   logic [7:0]  fr [$];
   logic [72:0] exp_q [3][$];
   logic [72:0] obs [3][$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   dxi_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u0 (
      .i_clk(clk), .i_rstn(rstn), .i_dxi_valid(v[0]), .i_dxi_data(d[0]), .o_dxi_ready(rdy[0]),
      .o_dxi_out_valid(ov[0]), .o_dxi_out_data(od[0]), .i_dxi_out_ready(ordy[0]), .o_dxi_out_last(ol[0]));
   dxi_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) u1 (
      .i_clk(clk), .i_rstn(rstn), .i_dxi_valid(v[1]), .i_dxi_data(d[1]), .o_dxi_ready(rdy[1]),
      .o_dxi_out_valid(ov[1]), .o_dxi_out_data(od[1]), .i_dxi_out_ready(ordy[1]), .o_dxi_out_last(ol[1]));
   dxi_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) u2 (
      .i_clk(clk), .i_rstn(rstn), .i_dxi_valid(v[2]), .i_dxi_data(d[2]), .o_dxi_ready(rdy[2]),
      .o_dxi_out_valid(ov[2]), .o_dxi_out_data(od[2]), .i_dxi_out_ready(ordy[2]), .o_dxi_out_last(ol[2]));

   // record every transferred window as {last, data}
   always @(negedge clk)
      for (int k = 0; k < 3; k++)
         if (ov[k] && ordy[k]) obs[k].push_back({ol[k], od[k]});

   // random downstream backpressure for instances in random-ready mode
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++)
         if (rr[k] != 0) ordy[k] = 1'($urandom_range(0, 1));
   end

   // every interior 3x3 window of the frame in fr, in raster order
   function automatic void model(input int k);
      for (int r = 2; r < H[k]; r++)
         for (int c = 2; c < W[k]; c++) begin
            logic [72:0] w;
            w[72] = (r == H[k] - 1) && (c == W[k] - 1);
            for (int i = 0; i < 9; i++) w[i*8 +: 8] = fr[(r - 2 + i / 3) * W[k] + c - 2 + i % 3];
            exp_q[k].push_back(w);
         end
   endfunction

   task automatic send(input int k, input logic [7:0] px, input int gap);
      int  n = 0;
      bit  a;
      v[k] = 1'b1;
      d[k] = px;
      do begin
         @(negedge clk);
         a = rdy[k];
         @(posedge clk);
         #1;
         n++;
      end while (!a && n < 200);
      if (!a) begin
         tests++;
         fails++;
         $display("FAIL send_timeout inst %0d: ready got 0 want 1", k);
      end
      v[k] = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ov[k] && n < 300);
      @(posedge clk);
      #1;
      if (ov[k]) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout inst %0d: valid got 1 want 0", k);
      end
   endtask

   task automatic clear(input int k);
      obs[k].delete();
      exp_q[k].delete();
      fr.delete();
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if ({ov[k], ol[k], od[k]} !== 74'd0) begin
            fails++;
            $display("FAIL reset_outputs inst %0d: got v=%b l=%b d=%h want all 0", k, ov[k], ol[k], od[k]);
         end
         tests++;
         if (rdy[k] !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready inst %0d: got %b want 1", k, rdy[k]);
         end
      end
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      clear(0);
      for (int i = 0; i < 16; i++) fr.push_back(8'(i));
      model(0);
      for (int i = 0; i < 16; i++) begin
         send(0, fr[i], 0);
         if (i == 9) begin
            tests++;
            if (ov[0] !== 1'b0) begin
               fails++;
               $display("FAIL basic_early_valid: got %b want 0", ov[0]);
            end
         end
         if (i == 10) begin
            tests++;
            if (ov[0] !== 1'b1 || od[0] !== 72'h0A0908060504020100 || ol[0] !== 1'b0) begin
               fails++;
               $display("FAIL basic_first_window: got v=%b d=%h l=%b want v=1 d=0a0908060504020100 l=0", ov[0], od[0], ol[0]);
            end
         end
      end
      drain(0);
      tests++;
      if (obs[0].size() !== 4) begin
         fails++;
         $display("FAIL basic_count: got %0d want 4", obs[0].size());
      end else begin
         tests++;
         if (obs[0][3] !== {1'b1, 72'h0F0E0D0B0A09070605}) begin
            fails++;
            $display("FAIL basic_last_window: got %h want 10f0e0d0b0a09070605", obs[0][3]);
         end
      end
      for (int i = 0; i < exp_q[0].size() && i < obs[0].size(); i++) begin
         tests++;
         if (obs[0][i] !== exp_q[0][i]) begin
            fails++;
            $display("FAIL basic_win%0d: got %h want %h", i, obs[0][i], exp_q[0][i]);
         end
      end
   endtask

   task automatic test_stall;
      clear(0);
      for (int i = 0; i < 16; i++) fr.push_back(8'(i));
      model(0);
      for (int i = 0; i < 11; i++) send(0, fr[i], 0);
      ordy[0] = 1'b0;
      v[0] = 1'b1;
      d[0] = fr[11];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if (rdy[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 72'h0A0908060504020100) begin
            fails++;
            $display("FAIL stall_hold cyc %0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=0a0908060504020100", c, rdy[0], ov[0], od[0]);
         end
         @(posedge clk);
         #1;
      end
      ordy[0] = 1'b1;
      for (int i = 11; i < 16; i++) send(0, fr[i], 0);
      drain(0);
      tests++;
      if (obs[0].size() !== exp_q[0].size()) begin
         fails++;
         $display("FAIL stall_count: got %0d want %0d", obs[0].size(), exp_q[0].size());
      end
      for (int i = 0; i < exp_q[0].size() && i < obs[0].size(); i++) begin
         tests++;
         if (obs[0][i] !== exp_q[0][i]) begin
            fails++;
            $display("FAIL stall_win%0d: got %h want %h", i, obs[0][i], exp_q[0][i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      clear(0);
      for (int f = 0; f < 2; f++) begin
         fr.delete();
         for (int i = 0; i < 16; i++) fr.push_back(8'(f * 16 + i));
         model(0);
         for (int i = 0; i < 16; i++) send(0, fr[i], 0);
      end
      drain(0);
      tests++;
      if (obs[0].size() !== 8) begin
         fails++;
         $display("FAIL b2b_count: got %0d want 8", obs[0].size());
      end else begin
         tests++;
         if (obs[0][4] !== {1'b0, 72'h1A1918161514121110}) begin
            fails++;
            $display("FAIL b2b_frame2_first: got %h want 01a1918161514121110", obs[0][4]);
         end
      end
      for (int i = 0; i < exp_q[0].size() && i < obs[0].size(); i++) begin
         tests++;
         if (obs[0][i] !== exp_q[0][i]) begin
            fails++;
            $display("FAIL b2b_win%0d: got %h want %h", i, obs[0][i], exp_q[0][i]);
         end
      end
   endtask

   task automatic test_uniform;
      clear(1);
      for (int i = 0; i < 64; i++) fr.push_back(8'h5F);
      model(1);
      for (int i = 0; i < 64; i++) send(1, fr[i], 0);
      drain(1);
      tests++;
      if (obs[1].size() !== 36) begin
         fails++;
         $display("FAIL uniform_count: got %0d want 36", obs[1].size());
      end
      for (int i = 0; i < exp_q[1].size() && i < obs[1].size(); i++) begin
         tests++;
         if (obs[1][i][71:0] !== {9{8'h5F}} || obs[1][i] !== exp_q[1][i]) begin
            fails++;
            $display("FAIL uniform_win%0d: got %h want %h", i, obs[1][i], exp_q[1][i]);
         end
      end
   endtask

   task automatic test_reset_midframe;
      clear(0);
      for (int i = 0; i < 6; i++) send(0, 8'(i + 8'h40), 0);
      rstn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if ({ov[k], ol[k], od[k]} !== 74'd0) begin
            fails++;
            $display("FAIL midreset_outputs inst %0d: got v=%b l=%b d=%h want all 0", k, ov[k], ol[k], od[k]);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      obs[0].delete();
      for (int i = 0; i < 16; i++) fr.push_back(8'(i));
      model(0);
      for (int i = 0; i < 16; i++) send(0, fr[i], 0);
      drain(0);
      tests++;
      if (obs[0].size() !== 4) begin
         fails++;
         $display("FAIL midreset_count: got %0d want 4", obs[0].size());
      end
      for (int i = 0; i < exp_q[0].size() && i < obs[0].size(); i++) begin
         tests++;
         if (obs[0][i] !== exp_q[0][i]) begin
            fails++;
            $display("FAIL midreset_win%0d: got %h want %h", i, obs[0][i], exp_q[0][i]);
         end
      end
   endtask

   task automatic test_random;
      int nlast = 0;
      clear(2);
      rr[2] = 1;
      for (int f = 0; f < 2; f++) begin
         fr.delete();
         for (int i = 0; i < 20; i++) fr.push_back(f == 0 ? 8'(i) : 8'($urandom));
         model(2);
         for (int i = 0; i < 20; i++) send(2, fr[i], int'($urandom_range(0, 3)));
      end
      drain(2);
      rr[2] = 0;
      ordy[2] = 1'b1;
      tests++;
      if (obs[2].size() !== 12) begin
         fails++;
         $display("FAIL random_count: got %0d want 12", obs[2].size());
      end
      for (int i = 0; i < obs[2].size(); i++) nlast += int'(obs[2][i][72]);
      tests++;
      if (nlast !== 2 || obs[2].size() < 6 || obs[2][5][72] !== 1'b1) begin
         fails++;
         $display("FAIL random_last: got %0d last flags want 2 (on windows 5 and 11)", nlast);
      end
      for (int i = 0; i < exp_q[2].size() && i < obs[2].size(); i++) begin
         tests++;
         if (obs[2][i] !== exp_q[2][i]) begin
            fails++;
            $display("FAIL random_win%0d: got %h want %h", i, obs[2][i], exp_q[2][i]);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0;
         d[k] = 8'h00;
         ordy[k] = 1'b1;
         rr[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_basic;
      test_stall;
      test_back_to_back;
      test_uniform;
      test_reset_midframe;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
